// File: rtl/ss_map_pkg.sv
// Shared types and default scroll limits for the sidescroller world-map selector.
package ss_map_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEXT = 2'd1,
        DIR_PREV = 2'd2
    } map_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } map_fsm_e;

    localparam logic [7:0] LOCX_HI_DEF = 8'h7C;
    localparam logic [7:0] LOCX_LO_DEF = 8'h00;

endpackage

// File: rtl/ss_map_delay.sv
// Shift register that delays the map select so ROM data already issued under
// the old map is still routed from the old map.
module ss_map_delay #(
    parameter int W   = 2,
    parameter int LAT = 1
) (
    input  logic         clk_75,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [LAT];

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[LAT-1];

endmodule

// File: rtl/ss_map_selector.sv
// World-map selector: picks one ROM for game-logic and video ports, switching
// only at frame boundaries. Define SS_MAP_WRAP_EN to make the world loop.
module ss_map_selector
    import ss_map_pkg::*;
#(
    parameter int                NUM_MAPS = 4,
    parameter int                DATA_W   = 2,
    parameter int                LOCX_W   = 8,
    parameter logic [LOCX_W-1:0] LOCX_HI  = LOCX_W'(LOCX_HI_DEF),
    parameter logic [LOCX_W-1:0] LOCX_LO  = LOCX_W'(LOCX_LO_DEF),
    parameter int                BRAM_LAT = 1,
    localparam int               MAP_W    = $clog2(NUM_MAPS)
) (
    input  logic                       clk_75,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic [LOCX_W-1:0]          locx,
    input  logic                       force_valid,
    input  logic [MAP_W-1:0]           force_map,
    input  logic [NUM_MAPS*DATA_W-1:0] rom_data_a,
    input  logic [NUM_MAPS*DATA_W-1:0] rom_data_b,
    output logic [DATA_W-1:0]          worldmap_data,
    output logic [DATA_W-1:0]          world_pixel,
    output logic [MAP_W-1:0]           current_map,
    output logic                       switch_pending,
    output logic                       map_changed,
    output logic [1:0]                 fsm_state
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_PENDING = ST_PENDING;
    localparam logic [1:0] S_COMMIT  = ST_COMMIT;

    localparam logic [MAP_W-1:0] LAST = MAP_W'(NUM_MAPS - 1);
`ifdef SS_MAP_WRAP_EN
    localparam logic [MAP_W-1:0] END_NEXT = '0;
    localparam logic [MAP_W-1:0] END_PREV = LAST;
`else
    localparam logic [MAP_W-1:0] END_NEXT = LAST;
    localparam logic [MAP_W-1:0] END_PREV = '0;
`endif

    logic [1:0]        state;
    logic [LOCX_W-1:0] locx_q, locx_q2;
    logic [MAP_W-1:0]  target, calc, sel_d;
    map_dir_e          ev_dir, pend_dir, req_dir, held_dir;
    logic              live_force, live_valid, req_valid, req_force, reverse;
    logic              held_valid, held_force;
    logic [MAP_W-1:0]  held_map, req_map;

    always_comb begin
        ev_dir = DIR_NONE;
        if (locx_q != locx_q2) begin
            if (locx_q == LOCX_HI)      ev_dir = DIR_NEXT;
            else if (locx_q == LOCX_LO) ev_dir = DIR_PREV;
        end
    end

    // A request seen during COMMIT is replayed from the held copy one cycle later.
    assign live_force = force_valid && ({1'b0, force_map} < (MAP_W+1)'(NUM_MAPS));
    assign live_valid = live_force || (ev_dir != DIR_NONE);
    assign req_valid  = live_valid || held_valid;
    assign req_force  = live_valid ? live_force : held_force;
    assign req_dir    = live_valid ? ev_dir     : held_dir;
    assign req_map    = live_valid ? force_map  : held_map;

    // Walking back the opposite way before the frame cancels the pending switch.
    assign reverse = !req_force &&
                     (((pend_dir == DIR_NEXT) && (req_dir == DIR_PREV)) ||
                      ((pend_dir == DIR_PREV) && (req_dir == DIR_NEXT)));

    always_comb begin
        calc = current_map;
        if (req_force)
            calc = req_map;
        else if (req_dir == DIR_NEXT)
            calc = (current_map == LAST) ? END_NEXT : current_map + 1'b1;
        else if (req_dir == DIR_PREV)
            calc = (current_map == '0) ? END_PREV : current_map - 1'b1;
    end

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            locx_q      <= '0;
            locx_q2     <= '0;
            current_map <= '0;
            target      <= '0;
            pend_dir    <= DIR_NONE;
            map_changed <= 1'b0;
            held_valid  <= 1'b0;
            held_force  <= 1'b0;
            held_dir    <= DIR_NONE;
            held_map    <= '0;
        end else begin
            locx_q      <= locx;
            locx_q2     <= locx_q;
            map_changed <= 1'b0;
            held_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && (calc != current_map)) begin
                        state    <= S_PENDING;
                        target   <= calc;
                        pend_dir <= req_force ? DIR_NONE : req_dir;
                    end
                end
                S_PENDING: begin
                    if (req_valid) begin
                        if (reverse || (calc == current_map)) begin
                            state    <= S_IDLE;
                            target   <= current_map;
                            pend_dir <= DIR_NONE;
                        end else begin
                            target   <= calc;
                            pend_dir <= req_force ? DIR_NONE : req_dir;
                        end
                    end else if (frame_start) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    current_map <= target;
                    map_changed <= 1'b1;
                    pend_dir    <= DIR_NONE;
                    state       <= S_IDLE;
                    if (live_valid) begin
                        held_valid <= 1'b1;
                        held_force <= live_force;
                        held_dir   <= ev_dir;
                        held_map   <= force_map;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign switch_pending = (state != S_IDLE);
    assign fsm_state      = state;

    ss_map_delay #(.W(MAP_W), .LAT(BRAM_LAT)) u_sel_delay (
        .clk_75 (clk_75),
        .reset  (reset),
        .d      (current_map),
        .q      (sel_d)
    );

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            worldmap_data <= '0;
            world_pixel   <= '0;
        end else begin
            worldmap_data <= rom_data_a[sel_d*DATA_W +: DATA_W];
            world_pixel   <= rom_data_b[sel_d*DATA_W +: DATA_W];
        end
    end

endmodule
